// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master and its daisy-chained slaves.
// Holds the FSM encoding, the SCK edge classification and the latched mode.
package spi_pkg;

  localparam int SPI_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    DONE     = 2'd2
  } state_t;

  typedef enum logic {
    LEADING  = 1'b0,
    TRAILING = 1'b1
  } edge_t;

  typedef struct packed {
    logic ckp;
    logic cph;
  } spi_mode_t;

  function automatic edge_t sample_edge(
    input logic cph
  );
    return cph ? TRAILING : LEADING;
  endfunction

endpackage

// File: rtl/spi_receiver.sv
// SPI slave for daisy chains: detects SCK edges by registering SCK,
// so every action trails the master's SCK edge by one clk.
module spi_receiver
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CPH,
  input  logic             CKP,
  input  logic             SS,
  input  logic             SCK,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] data_in,
  output logic             MISO,
  output logic [WIDTH-1:0] data_out
);

  logic             sck_q;
  logic             ss_q;
  logic             rx_bit;
  logic             miso_q;
  logic [WIDTH-1:0] sr;
  spi_mode_t        mode;
  edge_t            kind;
  logic             active;
  logic             sck_edge;

  assign active   = !SS && !ss_q;
  assign sck_edge = active && (SCK != sck_q);
  assign kind     = (sck_q == mode.ckp)
                  ? LEADING : TRAILING;
  assign MISO     = SS ? 1'b0 : miso_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q    <= 1'b0;
      ss_q     <= 1'b1;
      rx_bit   <= 1'b0;
      miso_q   <= 1'b0;
      sr       <= '0;
      mode     <= '0;
      data_out <= '0;
    end else begin
      sck_q <= SCK;
      ss_q  <= SS;
      if (ss_q && !SS) begin
        sr        <= data_in;
        mode.ckp  <= CKP;
        mode.cph  <= CPH;
        miso_q    <= CPH ? 1'b0
                   : data_in[WIDTH-1];
      end else if (!ss_q && SS) begin
        data_out <= sr;
        miso_q   <= 1'b0;
      end else if (sck_edge) begin
        unique case (kind)
          LEADING: begin
            if (mode.cph) miso_q <= sr[WIDTH-1];
            else          rx_bit <= MOSI;
          end
          TRAILING: begin
            sr <= {sr[WIDTH-2:0],
                   mode.cph ? MOSI : rx_bit};
            if (!mode.cph) miso_q <= sr[WIDTH-2];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_sck_gen.sv
// SCK phase counter: one SCK period spans 2*HALF_DIV clk cycles.
// lead/trail flag the cycle whose closing clk edge moves SCK.
module spi_sck_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ckp,
  output logic sck,
  output logic lead,
  output logic trail
);

  localparam int PW = $clog2(2 * HALF_DIV);
  localparam logic [PW-1:0] LEAD_AT =
    PW'(HALF_DIV - 1);
  localparam logic [PW-1:0] TRAIL_AT =
    PW'(2 * HALF_DIV - 1);

  logic [PW-1:0] phase;

  assign lead  = run && (phase == LEAD_AT);
  assign trail = run && (phase == TRAIL_AT);

  // Second half of the phase count drives the
  // non-idle level; idle level otherwise.
  assign sck = (run && (phase > LEAD_AT))
             ? ~ckp : ckp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (!run || trail) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

endmodule

// File: rtl/spi_transmitter.sv
// Full-duplex SPI master: MSB-first shift out on MOSI, MISO in at LSB.
// Mode bits are latched at start so mid-transfer changes are ignored.
module spi_transmitter
  import spi_pkg::*;
#(
  parameter int WIDTH    = SPI_WIDTH,
  parameter int HALF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             strt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             MISO,
  output logic             MOSI,
  output logic             CS,
  output logic             SCK,
  output logic [WIDTH-1:0] data_out,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(WIDTH - 1);

  state_t           state;
  spi_mode_t        mode;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bit_cnt;
  logic             rx_bit;
  logic             run;
  logic             lead;
  logic             trail;
  logic             sck_ckp;
  logic             samp_lead;
  logic             last;

  assign run       = (state == TRANSFER);
  assign samp_lead =
    (sample_edge(mode.cph) == LEADING);
  assign last      = (bit_cnt == LAST_BIT);

  // Idle SCK tracks the live CKP; once started,
  // only the latched polarity is used.
  assign sck_ckp = (state == IDLE) ? CKP : mode.ckp;

  spi_sck_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sck_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .ckp   (sck_ckp),
    .sck   (SCK),
    .lead  (lead),
    .trail (trail)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mode     <= '0;
      sr       <= '0;
      bit_cnt  <= '0;
      rx_bit   <= 1'b0;
      CS       <= 1'b1;
      MOSI     <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (strt) begin
            sr       <= data_in;
            mode.ckp <= CKP;
            mode.cph <= CPH;
            bit_cnt  <= '0;
            CS       <= 1'b0;
            if (!CPH) MOSI <= data_in[WIDTH-1];
            state    <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (lead) begin
            if (samp_lead) rx_bit <= MISO;
            else           MOSI   <= sr[WIDTH-1];
          end
          if (trail) begin
            sr <= {sr[WIDTH-2:0],
                   samp_lead ? rx_bit : MISO};
            bit_cnt <= bit_cnt + BW'(1);
            if (samp_lead && !last) begin
              MOSI <= sr[WIDTH-2];
            end
            if (last) state <= DONE;
          end
        end
        DONE: begin
          CS       <= 1'b1;
          done     <= 1'b1;
          data_out <= sr;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transmitter.sv
// Master plus two daisy-chained slaves, randomized transfers.
// Reference: chain rotation of words, SCK/CS/MOSI timing rules.
module tb_spi_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        CKP;
  logic        CPH;
  logic        strt;
  logic [15:0] m_din;
  logic [15:0] s1_din;
  logic [15:0] s2_din;
  logic        loop;
  logic        m_miso;
  logic        s1_miso;
  logic        s2_miso;
  logic        MOSI;
  logic        CS;
  logic        SCK;
  logic        done;
  logic [15:0] m_dout;
  logic [15:0] s1_dout;
  logic [15:0] s2_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign m_miso = loop ? MOSI : s2_miso;

  spi_transmitter #(
    .WIDTH    (16),
    .HALF_DIV (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .CKP      (CKP),
    .CPH      (CPH),
    .strt     (strt),
    .data_in  (m_din),
    .MISO     (m_miso),
    .MOSI     (MOSI),
    .CS       (CS),
    .SCK      (SCK),
    .data_out (m_dout),
    .done     (done)
  );

  spi_receiver #(.WIDTH(16)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .CPH      (CPH),
    .CKP      (CKP),
    .SS       (CS),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .data_in  (s1_din),
    .MISO     (s1_miso),
    .data_out (s1_dout)
  );

  spi_receiver #(.WIDTH(16)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .CPH      (CPH),
    .CKP      (CKP),
    .SS       (CS),
    .SCK      (SCK),
    .MOSI     (s1_miso),
    .data_in  (s2_din),
    .MISO     (s2_miso),
    .data_out (s2_dout)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Bus monitor: only writer of these counters.
  logic        mon_ckp = 1'b0;
  logic        mon_cph = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;
  logic        prev_mosi = 1'b0;
  logic        to_act;
  logic        to_idle;
  logic [31:0] mosi_word = '0;
  int cs_low = 0;
  int pulses = 0;
  int done_cnt = 0;
  int mosi_viol = 0;

  always @(negedge clk) begin
    to_act  = (SCK != prev_sck) && (SCK != mon_ckp);
    to_idle = (SCK != prev_sck) && (SCK == mon_ckp);
    if (!CS) begin
      cs_low++;
      if (!prev_cs) begin
        if (to_act) pulses++;
        if (mon_cph ? to_idle : to_act) begin
          mosi_word = {mosi_word[30:0], MOSI};
        end
        if ((MOSI != prev_mosi) &&
            !(mon_cph ? to_act : to_idle)) begin
          mosi_viol++;
        end
      end
    end
    if (done) done_cnt++;
    prev_cs   = CS;
    prev_sck  = SCK;
    prev_mosi = MOSI;
  end

  int          b_cs;
  int          b_pulses;
  int          b_done;
  int          b_viol;
  logic [15:0] exp_m;
  logic [15:0] exp_s1;
  logic [15:0] exp_s2;
  logic [15:0] exp_mosi;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(
    input logic        ckp,
    input logic        cph,
    input logic [15:0] m,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        lp
  );
    tick();
    CKP     = ckp;
    CPH     = cph;
    m_din   = m;
    s1_din  = a;
    s2_din  = b;
    loop    = lp;
    mon_ckp = ckp;
    mon_cph = cph;
    b_cs     = cs_low;
    b_pulses = pulses;
    b_done   = done_cnt;
    b_viol   = mosi_viol;
    exp_mosi = m;
    exp_s1   = m;
    exp_s2   = a;
    exp_m    = lp ? m : b;
    strt = 1'b1;
    tick();
    tick();
    strt = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    for (int i = 0; i < 300 && !done; i++) tick();
    check({tag, "_done"}, 32'(done), 1);
    repeat (4) tick();
    check({tag, "_m_rx"}, 32'(m_dout), 32'(exp_m));
    check({tag, "_s1_rx"}, 32'(s1_dout), 32'(exp_s1));
    check({tag, "_s2_rx"}, 32'(s2_dout), 32'(exp_s2));
    check({tag, "_mosi_bits"},
          32'(mosi_word[15:0]), 32'(exp_mosi));
    check({tag, "_cs_low"}, cs_low - b_cs, 65);
    check({tag, "_pulses"}, pulses - b_pulses, 16);
    check({tag, "_done_cnt"}, done_cnt - b_done, 1);
    check({tag, "_mosi_edge"}, mosi_viol - b_viol, 0);
    check({tag, "_cs_idle"}, 32'(CS), 1);
    check({tag, "_sck_idle"}, 32'(SCK), 32'(CKP));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;
    rst    = 1'b0;
    CKP    = 1'b1;
    CPH    = 1'b0;
    strt   = 1'b0;
    m_din  = '0;
    s1_din = '0;
    s2_din = '0;
    loop   = 1'b0;
    repeat (20) tick();
    check("rst_cs", 32'(CS), 1);
    check("rst_sck", 32'(SCK), 1);
    check("rst_mosi", 32'(MOSI), 0);
    check("rst_dout", 32'(m_dout), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b1;
    repeat (10) tick();
    check("quiet_cs", 32'(CS), 1);
    check("quiet_pulses", pulses, 0);
    check("quiet_done", done_cnt, 0);

    start_xfer(1, 0, 16'h0309, 16'h0807, 16'h0000, 0);
    finish_xfer("m10");
    start_xfer(0, 0, 16'h0309, 16'h0807, 16'h0000, 0);
    finish_xfer("m00");
    start_xfer(1, 1, 16'h0309, 16'h0807, 16'h0000, 0);
    finish_xfer("m11");
    start_xfer(0, 1, 16'h0309, 16'h0807, 16'h0000, 0);
    finish_xfer("m01");

    start_xfer(1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               16'hA5C3, 16'h1234, 16'h5678, 1);
    finish_xfer("loop");

    start_xfer(0, 1, 16'hBEEF, 16'h0F0F, 16'h7001, 0);
    repeat (20) tick();
    CKP  = 1'b1;
    strt = 1'b1;
    repeat (3) tick();
    strt = 1'b0;
    finish_xfer("tog");

    start_xfer(1, 0, 16'hC0DE, 16'h1111, 16'h2222, 0);
    for (int i = 0; i < 200 && pulses - b_pulses < 8; i++)
      tick();
    check("abort_at_bit7", pulses - b_pulses, 8);
    rst = 1'b0;
    #1;
    check("abort_cs", 32'(CS), 1);
    check("abort_sck", 32'(SCK), 32'(CKP));
    repeat (3) tick();
    check("abort_no_done", done_cnt - b_done, 0);
    rst = 1'b1;
    tick();
    start_xfer(1, 0, 16'h6A5F, 16'h3C3C, 16'h0E0E, 0);
    finish_xfer("after_abort");

    for (int t = 0; t < 6; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      start_xfer(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ra, rb, rc,
                 1'($urandom_range(0, 1)));
      finish_xfer($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_transmitter.md
Name:
spi_transmitter

Overview:
- 16-bit SPI master (transmitter) with a full-duplex shift register.
- Generates SCK and the active-low chip select CS from the single system clock.
- Shifts data_in out on MOSI, MSB first, while capturing MISO into data_out.
- Drives a daisy chain of spi_receiver slaves: master MOSI → slave1 → slave2 → master MISO. All slaves share CS and SCK and run on the same clk.

Parameters:
- WIDTH, 16, transfer length in bits (shift register width).
- HALF_DIV, 2, clk cycles per SCK half-period; SCK period = 2*HALF_DIV clk cycles.

Ports:
- clk  input  1  system clock; all logic is rising-edge clocked.
- rst  input  1  asynchronous active-low reset.
- CKP  input  1  clock polarity; SCK idle level (0 = idle low, 1 = idle high).
- CPH  input  1  clock phase (0 = sample on leading edge, 1 = sample on trailing edge).
- strt  input  1  start request; level-sampled in IDLE.
- data_in  input  WIDTH  word to transmit; latched at start.
- MISO  input  1  serial data from the last slave in the chain.
- MOSI  output  1  serial data to the first slave.
- CS  output  1  chip select, active low.
- SCK  output  1  serial clock.
- data_out  output  WIDTH  last word received; valid from done.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, CS=1, MOSI=0, data_out=0, done=0, counters=0, shift register=0.
- An active reset mid-transfer aborts the transfer immediately; no done pulse is generated.
- States: IDLE, TRANSFER, DONE.
- IDLE:
  - CS=1; SCK follows the live CKP input.
  - On a clk edge with strt=1: load shift register with data_in, latch CKP and CPH, clear bit and phase counters, CS=0, go to TRANSFER.
  - If CPH=0, MOSI = data_in[WIDTH-1] in the same cycle.
- TRANSFER:
  - A phase counter runs 0..2*HALF_DIV-1.
  - SCK = latched CKP for the first half of the phase count and ~CKP for the second half.
  - The leading edge is the transition into the second half; the trailing edge is the wrap back to phase 0.
  - CPH=0: sample MISO on the leading edge; shift and drive the next MOSI bit on the trailing edge.
  - CPH=1: drive the MOSI bit on the leading edge; sample MISO on the trailing edge.
  - Sampled bits enter the shift register LSB side; shifting is left, MSB first.
  - The bit counter increments at each trailing edge.
  - After the trailing edge of bit WIDTH-1, go to DONE.
- DONE (one clk cycle):
  - CS=1, SCK at idle level, data_out <= received word, done=1.
  - Then return to IDLE.
- Transfer timing:
  - CS low to CS high spans WIDTH*2*HALF_DIV+1 clk cycles (65 with defaults).
  - Exactly WIDTH SCK pulses occur while CS is low.
- strt is ignored outside IDLE.
- strt held high across DONE starts a new transfer one cycle after returning to IDLE; back-to-back transfers are allowed.
- CKP and CPH changes during TRANSFER have no effect (latched values are used). In IDLE, SCK tracks CKP immediately.
- MOSI holds its last value while idle.
- spi_receiver contract:
  - Port list mirrors the master: clk, rst, CPH, CKP, SS, SCK, MOSI, data_in; output MISO.
  - Detects SCK edges by registering SCK.
  - On SS falling: loads data_in; if CPH=0, presents data_in MSB on MISO.
  - Same sample/shift rules as the master, applied one clk after each SCK edge.
  - On SS rising: holds the received word; MISO=0 while SS=1.

Decomposition:
- Package spi_pkg holds:
  - WIDTH default.
  - State encoding: IDLE=2'd0, TRANSFER=2'd1, DONE=2'd2.
  - Edge-type enum: LEADING, TRAILING.
- One sub-module, spi_sck_gen: phase counter producing SCK plus leading/trailing strobes from CKP and HALF_DIV.
- spi_receiver is a separate block that reuses spi_pkg.

Test Plan:
- Reset with rst=0 for 20 clk, CKP=1 → CS=1, SCK=1, MOSI=0, data_out=0, done=0; raise rst, no activity without strt.
- Mode CKP=1,CPH=0, data_in=16'h0309, slave1 data_in=16'h0807, slave2 data_in=16'h0000, 2-cycle strt pulse → 16 SCK pulses idle-high; CS low for 65 cycles; master data_out=16'h0000; slave1 receives 16'h0309; slave2 receives 16'h0807; done pulses once.
- Repeat the same data in modes CKP=0/CPH=0, CKP=1/CPH=1 and CKP=0/CPH=1 → identical received words in each mode; SCK idle level equals CKP; MOSI changes only on the edge required by CPH.
- Direct loopback MOSI→MISO, data_in=16'hA5C3, any mode → data_out=16'hA5C3.
- strt pulsed again and CKP toggled mid-transfer → no restart, SCK polarity unchanged until DONE, single done pulse.
- rst=0 at bit 7 of a transfer → CS=1 and SCK at idle level immediately, no done; a new strt afterwards yields a full correct transfer.
